mrd_bank_sched: RTL and testbench

Ping-pong bank scheduler for the mixed-radix DFT core. It tracks the life cycle of both frame memories: load from sink, radix-2/3/4/5 passes on the shared butterfly core, and unload to source. From that state it drives the input, output and butterfly switch selects, and issues per-bank start pulses. Frames are processed strictly in arrival order, and the single radix core is granted to at most one bank at a time.

---
 rtl/mrd_sched_pkg.sv | 16 +
 rtl/mrd_bank_fsm.sv | 77 +++++++
 rtl/mrd_bank_sched.sv | 116 +++++++++++
 tb/tb_mrd_bank_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mrd_sched_pkg.sv
// Shared types and constants for the mixed-radix DFT ping-pong bank scheduler.
package mrd_sched_pkg;

   localparam int unsigned NUM_BANKS = 2;
   localparam int unsigned DFTPTS_W  = 12;

   typedef enum logic [2:0] {
      ST_EMPTY     = 3'd0,
      ST_LOAD      = 3'd1,
      ST_WAIT_CALC = 3'd2,
      ST_CALC      = 3'd3,
      ST_FULL      = 3'd4,
      ST_UNLOAD    = 3'd5
   } bank_state_t;

endpackage

// File: rtl/mrd_bank_fsm.sv
// Life-cycle FSM of one frame memory bank: holds the bank state, its latched
// point count and the registered start pulses. All inputs are already
// qualified by the scheduler, so every strobe seen here is a legal event.
module mrd_bank_fsm #(
   parameter int unsigned DFTPTS_W = 12
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sop_i,
   input  logic                        eop_i,
   input  logic                        grant_i,
   input  logic                        done_i,
   input  logic                        unload_i,
   input  logic                        out_eop_i,
   input  logic [DFTPTS_W-1:0]         dftpts_i,
   output mrd_sched_pkg::bank_state_t  state_o,
   output logic [DFTPTS_W-1:0]         dftpts_o,
   output logic                        calc_start_o,
   output logic                        out_start_o
);
   import mrd_sched_pkg::*;

   bank_state_t         state_q;
   logic [DFTPTS_W-1:0] dftpts_q;
   logic                calc_start_q;
   logic                out_start_q;

   // Bank state, point-count latch and one-cycle start pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         dftpts_q     <= '0;
         calc_start_q <= 1'b0;
         out_start_q  <= 1'b0;
      end else begin
         calc_start_q <= 1'b0;
         out_start_q  <= 1'b0;
         case (state_q)
            ST_EMPTY: begin
               if (sop_i) begin
                  dftpts_q <= dftpts_i;
                  // A single-beat frame skips LOAD entirely.
                  state_q  <= eop_i ? ST_WAIT_CALC : ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (eop_i) state_q <= ST_WAIT_CALC;
            end
            ST_WAIT_CALC: begin
               if (grant_i) begin
                  state_q      <= ST_CALC;
                  calc_start_q <= 1'b1;
               end
            end
            ST_CALC: begin
               if (done_i) state_q <= ST_FULL;
            end
            ST_FULL: begin
               if (unload_i) begin
                  state_q     <= ST_UNLOAD;
                  out_start_q <= 1'b1;
               end
            end
            ST_UNLOAD: begin
               if (out_eop_i) state_q <= ST_EMPTY;
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

   assign state_o      = state_q;
   assign dftpts_o     = dftpts_q;
   assign calc_start_o = calc_start_q;
   assign out_start_o  = out_start_q;

endmodule

// File: rtl/mrd_bank_sched.sv
// Ping-pong bank scheduler: owns the write/calc/read pointers, qualifies the
// stream and memory events against bank state, grants the shared radix core
// in arrival order and flags protocol violations.
module mrd_bank_sched #(
   parameter int unsigned NUM_BANKS = 2,
   parameter int unsigned DFTPTS_W  = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_sop_acc,
   input  logic                 in_eop_acc,
   input  logic [DFTPTS_W-1:0]  dftpts_in,
   input  logic [NUM_BANKS-1:0] calc_done,
   input  logic                 out_eop_acc,
   output logic                 sink_ready_en,
   output logic                 sw_in,
   output logic                 sw_out,
   output logic                 sw_rdx2345,
   output logic [NUM_BANKS-1:0] calc_start,
   output logic [DFTPTS_W-1:0]  calc_dftpts,
   output logic [NUM_BANKS-1:0] out_start,
   output logic [DFTPTS_W-1:0]  out_dftpts,
   output logic                 busy,
   output logic                 proto_err
);
   import mrd_sched_pkg::*;

   logic wr_ptr_q,    wr_ptr_d;
   logic calc_ptr_q,  calc_ptr_d;
   logic rd_ptr_q,    rd_ptr_d;
   logic proto_err_q, proto_err_d;

   bank_state_t         bank_st  [NUM_BANKS];
   logic [DFTPTS_W-1:0] bank_pts [NUM_BANKS];

   logic [NUM_BANKS-1:0] sop_b, eop_b, grant_b, done_b, unload_b, oeop_b;
   logic [NUM_BANKS-1:0] is_calc, is_busy;

   bank_state_t wr_st;
   logic        sop_ok, eop_ok, oeop_ok, core_busy;

   // Event qualification against registered state, pointer advance, sticky error.
   always_comb begin
      wr_st       = bank_st[wr_ptr_q];
      sop_ok      = in_sop_acc && (wr_st == ST_EMPTY);
      eop_ok      = in_eop_acc && ((wr_st == ST_LOAD) || sop_ok);
      oeop_ok     = out_eop_acc && (bank_st[rd_ptr_q] == ST_UNLOAD);
      core_busy   = |is_calc;

      wr_ptr_d    = wr_ptr_q ^ eop_ok;
      calc_ptr_d  = calc_ptr_q ^ (|done_b);
      rd_ptr_d    = rd_ptr_q ^ oeop_ok;

      proto_err_d = proto_err_q
                  | (in_sop_acc && (wr_st != ST_EMPTY))
                  | (in_eop_acc && !eop_ok)
                  | (|(calc_done & ~is_calc))
                  | (out_eop_acc && !oeop_ok);
   end

   // Pointer and error-flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= 1'b0;
         calc_ptr_q  <= 1'b0;
         rd_ptr_q    <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         calc_ptr_q  <= calc_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         proto_err_q <= proto_err_d;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      localparam logic BANK_ID = 1'(b);

      assign is_calc[b]  = (bank_st[b] == ST_CALC);
      assign is_busy[b]  = (bank_st[b] != ST_EMPTY);
      assign sop_b[b]    = sop_ok  && (wr_ptr_q == BANK_ID);
      assign eop_b[b]    = eop_ok  && (wr_ptr_q == BANK_ID);
      assign grant_b[b]  = (calc_ptr_q == BANK_ID) && (bank_st[b] == ST_WAIT_CALC) && !core_busy;
      assign done_b[b]   = calc_done[b] && is_calc[b];
      assign unload_b[b] = (rd_ptr_q == BANK_ID) && (bank_st[b] == ST_FULL);
      assign oeop_b[b]   = oeop_ok && (rd_ptr_q == BANK_ID);

      mrd_bank_fsm #(
         .DFTPTS_W (DFTPTS_W)
      ) u_bank (
         .clk          (clk),
         .rst          (rst),
         .sop_i        (sop_b[b]),
         .eop_i        (eop_b[b]),
         .grant_i      (grant_b[b]),
         .done_i       (done_b[b]),
         .unload_i     (unload_b[b]),
         .out_eop_i    (oeop_b[b]),
         .dftpts_i     (dftpts_in),
         .state_o      (bank_st[b]),
         .dftpts_o     (bank_pts[b]),
         .calc_start_o (calc_start[b]),
         .out_start_o  (out_start[b])
      );
   end

   assign sink_ready_en = (wr_st == ST_EMPTY) || (wr_st == ST_LOAD);
   assign sw_in         = wr_ptr_q;
   assign sw_rdx2345     = calc_ptr_q;
   assign sw_out        = rd_ptr_q;
   assign calc_dftpts   = bank_pts[calc_ptr_q];
   assign out_dftpts    = bank_pts[rd_ptr_q];
   assign busy          = |is_busy;
   assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_mrd_bank_sched.sv
// Bench for mrd_bank_sched: directed scenarios followed by constrained-random
// traffic, every cycle compared against a frame-sequence reference model.
module tb_mrd_bank_sched;

   localparam int unsigned W = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_sop_acc = 1'b0;
   logic          in_eop_acc = 1'b0;
   logic [W-1:0]  dftpts_in = '0;
   logic [1:0]    calc_done = '0;
   logic          out_eop_acc = 1'b0;
   logic          sink_ready_en, sw_in, sw_out, sw_rdx2345, busy, proto_err;
   logic [1:0]    calc_start, out_start;
   logic [W-1:0]  calc_dftpts, out_dftpts;

   always #5 clk = ~clk;

   mrd_bank_sched #(
      .NUM_BANKS (2),
      .DFTPTS_W  (W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_sop_acc    (in_sop_acc),
      .in_eop_acc    (in_eop_acc),
      .dftpts_in     (dftpts_in),
      .calc_done     (calc_done),
      .out_eop_acc   (out_eop_acc),
      .sink_ready_en (sink_ready_en),
      .sw_in         (sw_in),
      .sw_out        (sw_out),
      .sw_rdx2345    (sw_rdx2345),
      .calc_start    (calc_start),
      .calc_dftpts   (calc_dftpts),
      .out_start     (out_start),
      .out_dftpts    (out_dftpts),
      .busy          (busy),
      .proto_err     (proto_err)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: frames are numbered in arrival order and frame k lives
   // in bank k%2. Stage progress is tracked as frame counts.
   int           n_eop, n_cs, n_cd, n_os, n_oe;
   bit           sop_open, m_err;
   logic [W-1:0] m_pts [2];
   logic [1:0]   m_cs, m_os;

   function automatic void model_reset();
      n_eop = 0; n_cs = 0; n_cd = 0; n_os = 0; n_oe = 0;
      sop_open = 1'b0; m_err = 1'b0;
      m_pts[0] = '0; m_pts[1] = '0;
      m_cs = '0; m_os = '0;
   endfunction

   function automatic void model_edge();
      bit sop_v, eop_v, done_v, oeop_v, grant, unl;
      if (rst) begin
         model_reset();
         return;
      end
      m_cs   = '0;
      m_os   = '0;
      grant  = (n_cs < n_eop) && (n_cs == n_cd);
      unl    = (n_os < n_cd) && (n_os == n_oe);
      sop_v  = in_sop_acc && !sop_open && ((n_eop - n_oe) < 2);
      eop_v  = in_eop_acc && (sop_open || sop_v);
      oeop_v = out_eop_acc && (n_os > n_oe);
      done_v = 1'b0;
      for (int b = 0; b < 2; b++) begin
         if (calc_done[b]) begin
            if ((n_cs > n_cd) && (b == n_cd % 2)) done_v = 1'b1;
            else m_err = 1'b1;
         end
      end
      if (in_sop_acc && !sop_v)   m_err = 1'b1;
      if (in_eop_acc && !eop_v)   m_err = 1'b1;
      if (out_eop_acc && !oeop_v) m_err = 1'b1;
      if (sop_v) m_pts[n_eop % 2] = dftpts_in;
      if (grant) begin m_cs[n_cs % 2] = 1'b1; n_cs++; end
      if (done_v) n_cd++;
      if (unl) begin m_os[n_os % 2] = 1'b1; n_os++; end
      if (oeop_v) n_oe++;
      if (eop_v) begin
         n_eop++;
         sop_open = 1'b0;
      end else if (sop_v) begin
         sop_open = 1'b1;
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("sink_ready_en", 32'(sink_ready_en), 32'((n_eop - n_oe) < 2));
      check("busy",          32'(busy),          32'(sop_open || (n_eop != n_oe)));
      check("sw_in",         32'(sw_in),         32'(n_eop % 2));
      check("sw_rdx2345",    32'(sw_rdx2345),    32'(n_cd % 2));
      check("sw_out",        32'(sw_out),        32'(n_oe % 2));
      check("calc_start",    32'(calc_start),    32'(m_cs));
      check("out_start",     32'(out_start),     32'(m_os));
      check("calc_dftpts",   32'(calc_dftpts),   32'(m_pts[n_cd % 2]));
      check("out_dftpts",    32'(out_dftpts),    32'(m_pts[n_oe % 2]));
      check("proto_err",     32'(proto_err),     32'(m_err));
   endtask

   // One clock cycle: drive inputs, let the edge pass, update model, compare.
   task automatic cyc(input bit r, input bit sop, input bit eop, input logic [1:0] done,
                      input bit oeop, input logic [W-1:0] pts);
      rst         = r;
      in_sop_acc  = sop;
      in_eop_acc  = eop;
      calc_done   = done;
      out_eop_acc = oeop;
      dftpts_in   = pts;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, '0);
   endtask

   initial begin
      bit           sop, eop, oeop, r;
      logic [1:0]   done;
      logic [W-1:0] pts;

      model_reset();
      // Reset state
      do_reset();
      do_reset();
      check("rst_ready", 32'(sink_ready_en), 32'd1);
      check("rst_busy",  32'(busy),          32'd0);
      check("rst_perr",  32'(proto_err),     32'd0);

      // Single 12-point frame through all stages
      cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 12'd12);      // t0 SOP
      idle(10);                                        // t1..t10
      cyc(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, '0);          // t11 EOP
      check("s1_no_cs_t12", 32'(calc_start), 32'd0);
      idle(1);
      check("s1_cs_t13", 32'(calc_start), 32'b01);
      check("s1_cpts",   32'(calc_dftpts), 32'd12);
      idle(1);
      check("s1_cs_1cyc", 32'(calc_start), 32'd0);
      idle(26);
      cyc(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, '0);          // t40 calc_done
      check("s1_no_os_t41", 32'(out_start), 32'd0);
      idle(1);
      check("s1_os_t42", 32'(out_start), 32'b01);
      check("s1_opts",   32'(out_dftpts), 32'd12);
      idle(5);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, '0);
      check("s1_idle", 32'(busy), 32'd0);

      // Back-to-back 60-point then 1200-point frames
      do_reset();
      cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 12'd60);
      idle(3);
      cyc(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, '0);
      idle(1);
      check("s2_cs0", 32'(calc_start), 32'b01);
      cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 12'd1200);
      idle(2);
      cyc(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, '0);
      idle(3);
      check("s2_cs1_held", 32'(calc_start), 32'd0);
      check("s2_cpts60",   32'(calc_dftpts), 32'd60);
      cyc(1'b0, 1'b0, 1'b0, 2'b01, 1'b0, '0);
      check("s2_cs1_not_yet", 32'(calc_start), 32'd0);
      check("s2_cpts1200",    32'(calc_dftpts), 32'd1200);
      idle(1);
      check("s2_cs1", 32'(calc_start), 32'b10);
      check("s2_os0", 32'(out_start),  32'b01);

      // Both banks occupied with the source stalled
      check("s3_ready_lo_a", 32'(sink_ready_en), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, '0);
      idle(2);
      check("s3_ready_lo_b", 32'(sink_ready_en), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, '0);
      check("s3_ready_hi", 32'(sink_ready_en), 32'd1);
      check("s3_sw_in",    32'(sw_in),         32'd0);
      idle(1);
      check("s3_os1",   32'(out_start),  32'b10);
      check("s3_opts",  32'(out_dftpts), 32'd1200);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, '0);
      check("s3_idle", 32'(busy), 32'd0);

      // Single-beat frame
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 12'd5);
      check("s4_perr", 32'(proto_err), 32'd0);
      check("s4_busy", 32'(busy),      32'd1);
      check("s4_swin", 32'(sw_in),     32'd1);
      idle(1);
      check("s4_cs",   32'(calc_start),  32'b01);
      check("s4_cpts", 32'(calc_dftpts), 32'd5);

      // Spurious calc_done on an empty bank
      cyc(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, '0);
      check("s5_perr",  32'(proto_err),  32'd1);
      check("s5_swrdx", 32'(sw_rdx2345), 32'd0);
      check("s5_busy",  32'(busy),       32'd1);

      // Reset mid-CALC, then a fresh frame in bank 0
      do_reset();
      check("s6_busy",  32'(busy),        32'd0);
      check("s6_perr",  32'(proto_err),   32'd0);
      check("s6_cpts",  32'(calc_dftpts), 32'd0);
      cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 12'd33);
      cyc(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, '0);
      idle(1);
      check("s6_cs0",   32'(calc_start),  32'b01);
      check("s6_cpts2", 32'(calc_dftpts), 32'd33);

      // Constrained-random traffic with occasional violations and resets
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         sop  = !sop_open && ((n_eop - n_oe) < 2) && ($urandom_range(0, 3) == 0);
         eop  = (sop_open || sop) && ($urandom_range(0, 2) == 0);
         done = '0;
         if ((n_cs > n_cd) && ($urandom_range(0, 5) == 0)) done[n_cd % 2] = 1'b1;
         oeop = (n_os > n_oe) && ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 49) == 0) begin
            case ($urandom_range(0, 3))
               0: sop  = 1'b1;
               1: eop  = 1'b1;
               2: done = 2'($urandom_range(1, 3));
               default: oeop = 1'b1;
            endcase
         end
         r   = ($urandom_range(0, 399) == 0);
         pts = W'($urandom);
         cyc(r, sop, eop, done, oeop, pts);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
